// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared encodings and helpers for the AHB-Lite wait-state memory slave.
//   htrans_e : transfer type encoding
//   hsize_e  : transfer size encoding
//   HRESP_*  : response encoding (OKAY = 0, ERROR = 1)
//   state_e  : data-phase state machine states
//   be_mask  : byte-lane enable mask from low address bits and hsize
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // 2**size contiguous lanes starting at lane 'lo'; covers up to 8 lanes
    function automatic logic [7:0] be_mask(input logic [2:0] lo, input logic [2:0] size);
        logic [15:0] m;
        m = (16'd1 << (16'd1 << size)) - 16'd1;
        return 8'(m << lo);
    endfunction

endpackage

// File: rtl/ahbl_wait_mem_slave_if.sv
// ahbl_wait_mem_slave_if: AHB-Lite slave-side bus bundle plus wait configuration.
//   master modport drives hsel/haddr/htrans/hwrite/hsize/hburst/hprot/hwdata/
//   error/hready_in/wait_cfg and observes hrdata/hready/hresp; slave is the mirror.
interface ahbl_wait_mem_slave_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned RW  = 1,
    parameter int unsigned WCW = 4
);
    logic           hsel;
    logic [AW-1:0]  haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [2:0]     hsize;
    logic [2:0]     hburst;
    logic [3:0]     hprot;
    logic [DW-1:0]  hwdata;
    logic           error;
    logic           hready_in;
    logic [WCW-1:0] wait_cfg;
    logic [DW-1:0]  hrdata;
    logic           hready;
    logic [RW-1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
               error, hready_in, wait_cfg,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
               error, hready_in, wait_cfg,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahbl_be_gen.sv
// ahbl_be_gen: combinational byte-enable and alignment check for one address phase.
//   i_addr_lo    : byte offset within the data word
//   i_hsize      : transfer size
//   o_be         : DW/8 byte-lane enables
//   o_misaligned : address not aligned to the transfer size
//   o_size_bad   : transfer wider than the data bus
module ahbl_be_gen
    import ahbl_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [$clog2(DW/8)-1:0] i_addr_lo,
    input  logic [2:0]              i_hsize,
    output logic [DW/8-1:0]         o_be,
    output logic                    o_misaligned,
    output logic                    o_size_bad
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned BL = $clog2(NB);

    logic [2:0] w_lo;
    logic [2:0] w_amask;
    logic [7:0] w_be8;

    assign w_lo         = 3'(i_addr_lo);
    assign w_be8        = be_mask(w_lo, i_hsize);
    assign o_be         = NB'(w_be8);
    // low address bits that must be zero for this size
    assign w_amask      = 3'((4'd1 << i_hsize) - 4'd1);
    assign o_misaligned = |(w_lo & w_amask);
    assign o_size_bad   = (i_hsize > 3'(BL));
endmodule

// File: rtl/ahbl_wait_mem_slave.sv
// ahbl_wait_mem_slave: AHB-Lite memory slave with programmable wait states,
// byte/halfword write lanes, two-cycle ERROR response and read-after-write forwarding.
//   hclk    : bus clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : ahbl_wait_mem_slave_if slave modport (address/data phase signals,
//             error, hready_in, wait_cfg in; hrdata, hready, hresp out)
// Optional macro AHBL_PROT_CHK_EN: user-mode writes to the upper half of memory
// are answered with ERROR; without it hprot is ignored.
module ahbl_wait_mem_slave
    import ahbl_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned RW      = 1,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MAXWAIT = 15,
    parameter int unsigned WCW     = $clog2(MAXWAIT + 1)
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahbl_wait_mem_slave_if.slave  bus
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned BL = $clog2(NB);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [DW-1:0]  r_mem [DEPTH];

    state_e         r_state;
    logic [WCW-1:0] r_cnt;
    logic           r_hready;
    logic [RW-1:0]  r_hresp;
    logic [DW-1:0]  r_hrdata;
    logic           r_wr_pend;
    logic [IW-1:0]  r_widx;
    logic [NB-1:0]  r_be;

    logic [AW-1:0]  w_idx_full;
    logic [IW-1:0]  w_idx;
    logic           w_oor;
    logic [NB-1:0]  w_be;
    logic           w_misaligned;
    logic           w_size_bad;
    logic           w_prot_err;
    logic           w_err;
    logic           w_acc;
    logic           w_commit;
    logic [DW-1:0]  w_bemask;
    logic [DW-1:0]  w_mem_word;
    logic [DW-1:0]  w_rd_data;
    logic           w_unused;

    // address-phase decode
    assign w_idx_full = bus.haddr >> BL;
    assign w_idx      = w_idx_full[IW-1:0];
    assign w_oor      = (w_idx_full >= AW'(DEPTH));
    assign w_acc      = bus.hsel & bus.hready_in & bus.htrans[1];

    ahbl_be_gen #(.DW(DW)) u_be_gen (
        .i_addr_lo    (bus.haddr[BL-1:0]),
        .i_hsize      (bus.hsize),
        .o_be         (w_be),
        .o_misaligned (w_misaligned),
        .o_size_bad   (w_size_bad)
    );

`ifdef AHBL_PROT_CHK_EN
    assign w_prot_err = bus.hwrite & ~bus.hprot[1] & (w_idx_full >= AW'(DEPTH / 2));
`else
    assign w_prot_err = 1'b0;
`endif

    assign w_err = bus.error | w_oor | w_size_bad | w_misaligned | w_prot_err;

    // pending write completes on the edge that ends its OKAY data phase
    assign w_commit = r_wr_pend & r_hready & (r_hresp == RW'(HRESP_OKAY));

    always_comb begin
        w_bemask = '0;
        for (int b = 0; b < NB; b++) begin
            w_bemask[8*b +: 8] = {8{r_be[b]}};
        end
    end

    // read data, merged with a write committing to the same word on this edge
    assign w_mem_word = r_mem[w_idx];
    assign w_rd_data  = (w_commit && (r_widx == w_idx))
                      ? ((w_mem_word & ~w_bemask) | (bus.hwdata & w_bemask))
                      : w_mem_word;

    // memory array: not reset
    always_ff @(posedge hclk) begin
        if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (r_be[b]) begin
                    r_mem[r_widx][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    // data-phase state machine with registered responses
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hready  <= 1'b1;
            r_hresp   <= RW'(HRESP_OKAY);
            r_hrdata  <= '0;
            r_wr_pend <= 1'b0;
            r_widx    <= '0;
            r_be      <= '0;
        end else begin
            if (w_commit) begin
                r_wr_pend <= 1'b0;
            end
            case (r_state)
                ST_WAIT: begin
                    r_cnt <= r_cnt - WCW'(1);
                    if (r_cnt <= WCW'(1)) begin
                        r_hready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ERR1: begin
                    r_hready <= 1'b1;
                    r_state  <= ST_ERR2;
                end
                default: begin
                    // IDLE and ERR2 both end a data phase and may accept a new one
                    r_hready <= 1'b1;
                    r_hresp  <= RW'(HRESP_OKAY);
                    r_state  <= ST_IDLE;
                    if (w_acc) begin
                        if (w_err) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= RW'(HRESP_ERROR);
                        end else begin
                            if (bus.hwrite) begin
                                r_wr_pend <= 1'b1;
                                r_widx    <= w_idx;
                                r_be      <= w_be;
                            end else begin
                                r_hrdata <= w_rd_data;
                            end
                            if (bus.wait_cfg != '0) begin
                                r_state  <= ST_WAIT;
                                r_cnt    <= bus.wait_cfg;
                                r_hready <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.hready = r_hready;
    assign bus.hresp  = r_hresp;
    assign bus.hrdata = r_hrdata;

    assign w_unused = ^{bus.hburst, bus.hprot, bus.htrans[0]};
endmodule

// File: doc/ahbl_wait_mem_slave.md
Name: ahbl_wait_mem_slave

Overview:
- Second-generation AHB-Lite memory slave, and the DUT behind the existing bus interface.
- Parametrised in address width, data width, depth and response width.
- Adds per-transfer programmable wait states, byte/halfword write lanes, a compliant two-cycle ERROR response, and read-after-write forwarding.
- Sits behind the decoder on the AHB-Lite bus; the bench's driver and monitor clocking blocks connect to it unchanged, plus a wait-configuration port.

Parameters:
- AW, 32: address bus width (byte address).
- DW, 32: data bus width; one of 32 or 64.
- RW, 1: hresp width; OKAY = 0, ERROR = 1.
- DEPTH, 1024: memory depth in DW-bit words.
- MAXWAIT, 15: largest programmable wait count; WCW = $clog2(MAXWAIT+1).

Ports:
- hclk  in  1  bus clock, rising edge.
- hresetn  in  1  reset; asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  AW  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type; accepted, not otherwise used.
- hprot  in  4  protection control.
- hwdata  in  DW  write data, valid in the data phase.
- error  in  1  sampled in the address phase; forces an ERROR response.
- hready_in  in  1  bus-wide hready from the multiplexor.
- wait_cfg  in  WCW  number of wait cycles inserted per accepted transfer; sampled in the address phase.
- hrdata  out  DW  read data.
- hready  out  1  hreadyout of this slave.
- hresp  out  RW  transfer response.

Behaviour:
- **Reset**: hready = 1, hresp = 0, hrdata = 0, state = IDLE, captured address-phase registers = 0. Memory contents are not reset. Reset asserted mid-transfer aborts it and no write is committed.
- **Acceptance**: a transfer is accepted at a rising edge where hsel & hready_in & htrans[1] = 1.
  - IDLE or BUSY with hsel = 1 gives a zero-wait OKAY response.
  - Nothing is captured when hready_in = 0.
- **Error condition**, evaluated at acceptance; any of:
  - error = 1;
  - word index (haddr >> log2(DW/8)) >= DEPTH;
  - hsize > log2(DW/8);
  - haddr misaligned for hsize.
- **State machine**: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accept a good transfer with wait_cfg = 0 -> stay IDLE; the data phase completes next cycle with hready = 1, OKAY.
  - IDLE: accept a good transfer with wait_cfg = N > 0 -> WAIT with counter = N. hready = 0 for N cycles, then hready = 1, OKAY.
  - Accept with the error condition -> ERR1.
  - ERR1: hready = 0, hresp = 1 -> ERR2. ERR2: hready = 1, hresp = 1 -> IDLE, or accept a new transfer.
  - The counter decrements once per cycle; wait_cfg changes during WAIT are ignored.
  - A new transfer may be accepted in the last (hready = 1) cycle of every data phase.
- **Writes**:
  - Byte enables are derived from haddr[log2(DW/8)-1:0] and hsize.
  - The write commits at the edge that ends the data phase (hready = 1 and OKAY), with hwdata masked by the enables.
  - Errored writes never commit.
- **Reads**:
  - hrdata is registered, loaded at the accepting edge from memory at the word index, and held until the next read is accepted.
  - The full word is returned; the master selects the lanes.
  - Errored reads leave hrdata unchanged.
- **Forwarding**: if a write commits at the same edge a read of the same word is accepted, hrdata takes the merged value (new bytes from hwdata per enable, the rest from memory). There is no stale-read window.

Optional Feature:
- Macro: AHBL_PROT_CHK_EN.
- Defined: a write accepted with hprot[1] = 0 (user) to the upper half of memory (word index >= DEPTH/2) is an error condition and gets the two-cycle ERROR response. Reads are unaffected.
- Undefined: hprot is ignored entirely.

Decomposition:
- Package ahbl_pkg holds:
  - htrans, hsize and hresp encodings as enums/localparams;
  - the state enum {IDLE, WAIT, ERR1, ERR2};
  - the function computing the byte-enable mask from the low address bits and hsize.
- One sub-module, ahbl_be_gen: combinational alignment check plus the DW/8-bit enable vector. It is instantiated once, on the address-phase signals.

Test Plan:
- Reset then IDLE bus -> hready = 1, hresp = 0, hrdata = 0.
- Write word 0xDEADBEEF to 0x10 with wait_cfg = 0, then read 0x10 back-to-back -> read data phase completes in 1 cycle with hrdata = 0xDEADBEEF (forwarding path).
- wait_cfg = 3: read 0x20 -> hready low for exactly 3 cycles, then high with OKAY and hrdata = memory contents.
- Byte write 0xAA to 0x13 over 0x11223344 at 0x10 -> subsequent read returns 0xAA223344.
- Read 0x1000 (out of range for DEPTH = 1024, DW = 32), or any access with error = 1 -> hready 0 / hresp 1 for one cycle, then hready 1 / hresp 1; a write gated this way leaves memory unchanged.
- With AHBL_PROT_CHK_EN: user-mode write to 0x800 -> ERROR; privileged write to 0x800 -> OKAY. Without the macro, both -> OKAY.
